// File: rtl/xif_coproc_alu_frontend_if.sv
// Issue, commit and result channels between the CPU and the ALU coprocessor.
interface xif_coproc_alu_frontend_if #(
  parameter int X_ID_WIDTH = 4
);
  logic                  issue_valid;
  logic                  issue_ready;
  logic [31:0]           issue_instr;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic [31:0]           issue_rs0;
  logic [31:0]           issue_rs1;
  logic [1:0]            issue_rs_valid;
  logic                  issue_accept;
  logic                  issue_writeback;
  logic                  issue_dualwrite;
  logic                  issue_dualread;
  logic                  issue_loadstore;
  logic                  issue_exc;

  logic                  commit_valid;
  logic [X_ID_WIDTH-1:0] commit_id;
  logic                  commit_kill;

  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [31:0]           result_data;
  logic [4:0]            result_rd;
  logic                  result_we;
  logic                  result_exc;

  modport master (
    output issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
    input  issue_ready, issue_accept, issue_writeback, issue_dualwrite, issue_dualread,
           issue_loadstore, issue_exc,
    output commit_valid, commit_id, commit_kill,
    input  result_valid, result_id, result_data, result_rd, result_we, result_exc,
    output result_ready
  );

  modport slave (
    input  issue_valid, issue_instr, issue_id, issue_rs0, issue_rs1, issue_rs_valid,
    output issue_ready, issue_accept, issue_writeback, issue_dualwrite, issue_dualread,
           issue_loadstore, issue_exc,
    input  commit_valid, commit_id, commit_kill,
    output result_valid, result_id, result_data, result_rd, result_we, result_exc,
    input  result_ready
  );
endinterface

// File: rtl/xif_coproc_alu_frontend.sv
// Coprocessor endpoint: decodes custom-0 ALU ops, holds them in an in-order
// queue until committed or killed, and returns results in issue order.
module xif_coproc_alu_frontend #(
  parameter  int X_ID_WIDTH = 4,
  parameter  int DEPTH      = 4,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  xif_coproc_alu_frontend_if.slave xif,
  output logic [CW-1:0]            count
);

  logic [X_ID_WIDTH-1:0] id_q [DEPTH];
  logic [X_ID_WIDTH-1:0] id_d [DEPTH];
  logic [4:0]            rd_q [DEPTH];
  logic [4:0]            rd_d [DEPTH];
  logic [2:0]            f3_q [DEPTH];
  logic [2:0]            f3_d [DEPTH];
  logic [31:0]           a_q  [DEPTH];
  logic [31:0]           a_d  [DEPTH];
  logic [31:0]           b_q  [DEPTH];
  logic [31:0]           b_d  [DEPTH];
  logic [DEPTH-1:0]      cmt_q, cmt_d, kil_q, kil_d;
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;

  logic [PW-1:0]         slot [DEPTH];
  logic                  decode_ok, room, push, pop, head_cmt, head_kil, match_found;
  logic                  unused_instr_bits;

  // rs1/rs2 register fields are not needed: operands arrive by value
  assign unused_instr_bits = ^xif.issue_instr[24:15];
  assign count = count_q;

  function automatic logic [31:0] alu(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
    logic [63:0] rot;
    rot = {a, a} << b[4:0];
    case (f)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = a ^ b;
      3'd3:    alu = (a < b) ? a : b;
      3'd4:    alu = (a > b) ? a : b;
      3'd5:    alu = rot[63:32];
      default: alu = 32'd0;
    endcase
  endfunction

  // Decode, issue handshake and head-of-queue result presentation
  always_comb begin
    decode_ok = (xif.issue_instr[6:0] == 7'b0001011) && (xif.issue_instr[31:25] == 7'd0)
                && (xif.issue_instr[14:12] <= 3'd5);
    room      = (count_q < CW'(DEPTH)) && (xif.issue_rs_valid == 2'b11);
    push      = xif.issue_valid && decode_ok && room;
    head_cmt  = (count_q != '0) && cmt_q[head_q];
    head_kil  = (count_q != '0) && kil_q[head_q];
    pop       = head_kil || (head_cmt && xif.result_ready);

    xif.issue_ready     = decode_ok ? room : 1'b1;
    xif.issue_accept    = push;
    xif.issue_writeback = push;
    xif.issue_dualwrite = 1'b0;
    xif.issue_dualread  = 1'b0;
    xif.issue_loadstore = 1'b0;
    xif.issue_exc       = 1'b0;

    xif.result_valid = head_cmt;
    xif.result_id    = head_cmt ? id_q[head_q] : '0;
    xif.result_data  = head_cmt ? alu(f3_q[head_q], a_q[head_q], b_q[head_q]) : 32'd0;
    xif.result_rd    = head_cmt ? rd_q[head_q] : 5'd0;
    xif.result_we    = head_cmt && (rd_q[head_q] != 5'd0);
    xif.result_exc   = 1'b0;
  end

  // Physical slot of the i-th oldest entry
  always_comb begin
    for (int i = 0; i < DEPTH; i++) slot[i] = head_q + PW'(i);
  end

  // Commit/kill lookup, push, pop and pointer/occupancy update
  always_comb begin
    id_d = id_q; rd_d = rd_q; f3_d = f3_q; a_d = a_q; b_d = b_q;
    cmt_d = cmt_q; kil_d = kil_q;
    head_d = head_q; tail_d = tail_q; count_d = count_q;
    match_found = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      if (xif.commit_valid && !match_found && (CW'(i) < count_q)
          && (id_q[slot[i]] == xif.commit_id) && !cmt_q[slot[i]] && !kil_q[slot[i]]) begin
        match_found = 1'b1;
        if (xif.commit_kill) kil_d[slot[i]] = 1'b1;
        else                 cmt_d[slot[i]] = 1'b1;
      end
    end

    // A commit naming the instruction being pushed right now lands on the new entry
    if (push) begin
      id_d[tail_q]  = xif.issue_id;
      rd_d[tail_q]  = xif.issue_instr[11:7];
      f3_d[tail_q]  = xif.issue_instr[14:12];
      a_d[tail_q]   = xif.issue_rs0;
      b_d[tail_q]   = xif.issue_rs1;
      cmt_d[tail_q] = xif.commit_valid && !match_found && (xif.commit_id == xif.issue_id)
                      && !xif.commit_kill;
      kil_d[tail_q] = xif.commit_valid && !match_found && (xif.commit_id == xif.issue_id)
                      && xif.commit_kill;
      tail_d        = tail_q + PW'(1);
    end

    if (pop) head_d = head_q + PW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        id_q[i] <= '0;
        rd_q[i] <= '0;
        f3_q[i] <= '0;
        a_q[i]  <= '0;
        b_q[i]  <= '0;
      end
      cmt_q   <= '0;
      kil_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      id_q    <= id_d;
      rd_q    <= rd_d;
      f3_q    <= f3_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cmt_q   <= cmt_d;
      kil_q   <= kil_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_xif_coproc_alu_frontend.sv
// Scoreboard bench: the stimulus process runs a transaction-level model of the
// queue and pushes expected results; a separate monitor pops and compares them.
module tb_xif_coproc_alu_frontend;
  localparam int XW = 4;
  localparam int D  = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] count;

  xif_coproc_alu_frontend_if #(.X_ID_WIDTH(XW)) xif ();

  xif_coproc_alu_frontend #(.X_ID_WIDTH(XW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .xif(xif.slave), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] res;
    bit          cmt;
    bit          kil;
    bit          sent;
  } ent_t;

  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  ent_t mq[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h @%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [31:0] r;
    case (f)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a ^ b;
      3'd3: r = (a < b) ? a : b;
      3'd4: r = (a > b) ? a : b;
      default: begin
        r = a;
        for (int k = 0; k < int'(b[4:0]); k++) r = {r[30:0], r[31]};
      end
    endcase
    return r;
  endfunction

  function automatic bit legal(input logic [31:0] instr);
    return instr[6:0] == 7'h0B && instr[31:25] == 7'd0 && instr[14:12] <= 3'd5;
  endfunction

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [4:0] rd);
    return {7'd0, 5'd3, 5'd2, f3, rd, 7'h0B};
  endfunction

  // One clock cycle: drive after the edge, check and advance the model before the next
  task automatic cycle(input bit iv, input logic [31:0] instr, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b, input logic [1:0] rsv,
                       input bit cv, input logic [3:0] cid, input bit ck, input bit rr);
    bit ok, room, e_acc, e_rv, do_pop, hit;
    ent_t n;
    @(posedge clk); #1;
    xif.issue_valid = iv; xif.issue_instr = instr; xif.issue_id = id;
    xif.issue_rs0 = a; xif.issue_rs1 = b; xif.issue_rs_valid = rsv;
    xif.commit_valid = cv; xif.commit_id = cid; xif.commit_kill = ck;
    xif.result_ready = rr;
    @(negedge clk);
    ok    = legal(instr);
    room  = (mq.size() < D) && (rsv == 2'b11);
    e_acc = iv && ok && room;
    e_rv  = (mq.size() > 0) && mq[0].cmt;
    chk("issue_ready", 32'(xif.issue_ready), ok ? 32'(room) : 32'd1);
    chk("issue_accept", 32'(xif.issue_accept), 32'(e_acc));
    chk("issue_writeback", 32'(xif.issue_writeback), 32'(e_acc));
    chk("count", 32'(count), 32'(mq.size()));
    chk("result_valid", 32'(xif.result_valid), 32'(e_rv));

    do_pop = (mq.size() > 0) && (mq[0].kil || (mq[0].cmt && rr));
    hit = 0;
    if (cv) begin
      foreach (mq[i]) begin
        if (!hit && mq[i].id == cid && !mq[i].cmt && !mq[i].kil) begin
          hit = 1;
          if (ck) mq[i].kil = 1; else mq[i].cmt = 1;
        end
      end
    end
    if (e_acc) begin
      n.id = id; n.rd = instr[11:7]; n.res = ref_op(instr[14:12], a, b);
      n.cmt = cv && !hit && cid == id && !ck;
      n.kil = cv && !hit && cid == id && ck;
      n.sent = 0;
      mq.push_back(n);
    end
    if (do_pop) void'(mq.pop_front());
    // Every committed entry with no unresolved elder becomes an expected result
    foreach (mq[i]) begin
      if (!mq[i].cmt && !mq[i].kil) break;
      if (mq[i].cmt && !mq[i].sent) begin
        exp_q.push_back('{id: mq[i].id, rd: mq[i].rd, data: mq[i].res});
        mq[i].sent = 1;
      end
    end
  endtask

  task automatic idle(input int n, input bit rr);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 2'b11, 0, 0, 0, rr);
  endtask

  task automatic commit(input logic [3:0] cid, input bit ck, input bit rr);
    cycle(0, 0, 0, 0, 0, 2'b11, 1, cid, ck, rr);
  endtask

  task automatic issue(input logic [2:0] f3, input logic [4:0] rd, input logic [3:0] id,
                       input logic [31:0] a, input logic [31:0] b, input bit rr);
    cycle(1, mk(f3, rd), id, a, b, 2'b11, 0, 0, 0, rr);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    xif.issue_valid = 0; xif.commit_valid = 0; xif.result_ready = 1;
    @(negedge clk);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_result_valid", 32'(xif.result_valid), 32'd0);
    mq.delete();
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every result handshake and checks hold stability
  logic        prev_hold = 0;
  logic [3:0]  prev_id;
  logic [31:0] prev_data;
  logic [4:0]  prev_rd;
  logic        prev_we;
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_id", 32'(xif.result_id), 32'(prev_id));
        chk("hold_data", xif.result_data, prev_data);
        chk("hold_rd", 32'(xif.result_rd), 32'(prev_rd));
        chk("hold_we", 32'(xif.result_we), 32'(prev_we));
      end
      if (xif.result_valid && xif.result_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual_id=%h required=none @%0t",
                   xif.result_id, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_id", 32'(xif.result_id), 32'(e.id));
          chk("result_data", xif.result_data, e.data);
          chk("result_rd", 32'(xif.result_rd), 32'(e.rd));
          chk("result_we", 32'(xif.result_we), 32'(e.rd != 5'd0));
          chk("result_exc", 32'(xif.result_exc), 32'd0);
        end
      end
      prev_hold = xif.result_valid && !xif.result_ready;
      prev_id   = xif.result_id;
      prev_data = xif.result_data;
      prev_rd   = xif.result_rd;
      prev_we   = xif.result_we;
    end
  end

  initial begin
    rst = 1'b1;
    xif.issue_valid = 0; xif.issue_instr = mk(3'd0, 5'd1); xif.issue_id = 0;
    xif.issue_rs0 = 0; xif.issue_rs1 = 0; xif.issue_rs_valid = 2'b11;
    xif.commit_valid = 0; xif.commit_id = 0; xif.commit_kill = 0; xif.result_ready = 0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_result_valid", 32'(xif.result_valid), 32'd0);
    chk("rst_result_data", xif.result_data, 32'd0);
    chk("rst_result_id", 32'(xif.result_id), 32'd0);
    chk("rst_issue_ready", 32'(xif.issue_ready), 32'd1);
    chk("rst_issue_accept", 32'(xif.issue_accept), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Each op with a same-cycle commit
    cycle(1, mk(3'd0, 5'd5), 4'd1, 32'hFFFF_FFFF, 32'd2, 2'b11, 1, 4'd1, 0, 1);
    cycle(1, mk(3'd5, 5'd6), 4'd2, 32'h8000_0001, 32'h21, 2'b11, 1, 4'd2, 0, 1);
    cycle(1, mk(3'd3, 5'd0), 4'd3, 32'd5, 32'hFFFF_FFFF, 2'b11, 1, 4'd3, 0, 1);
    cycle(1, mk(3'd1, 5'd7), 4'd4, 32'd3, 32'd10, 2'b11, 1, 4'd4, 0, 1);
    cycle(1, mk(3'd2, 5'd8), 4'd5, 32'hA5A5_0F0F, 32'hFFFF_0000, 2'b11, 1, 4'd5, 0, 1);
    cycle(1, mk(3'd4, 5'd9), 4'd6, 32'd5, 32'hFFFF_FFFF, 2'b11, 1, 4'd6, 0, 1);
    idle(2, 1);

    // Rejects, then commits for those IDs must produce nothing
    cycle(1, {7'd0, 5'd3, 5'd2, 3'd0, 5'd4, 7'h33}, 4'd9, 1, 2, 2'b11, 0, 0, 0, 1);
    cycle(1, mk(3'd6, 5'd4), 4'd10, 1, 2, 2'b11, 0, 0, 0, 1);
    commit(4'd9, 0, 1);
    commit(4'd10, 0, 1);
    idle(2, 1);

    // Fill, reject a fifth, commit under backpressure, then release
    for (int i = 0; i < 4; i++) issue(3'(i), 5'(i + 1), 4'(i), 32'(100 + i), 32'(7 * i), 0);
    issue(3'd0, 5'd1, 4'd4, 1, 1, 0);
    for (int i = 0; i < 4; i++) commit(4'(i), 0, 0);
    idle(3, 0);
    idle(6, 1);

    // Out-of-order commit and kill
    issue(3'd0, 5'd1, 4'd1, 10, 1, 1);
    issue(3'd0, 5'd2, 4'd2, 20, 2, 1);
    issue(3'd0, 5'd3, 4'd3, 30, 3, 1);
    commit(4'd3, 0, 1);
    commit(4'd2, 1, 1);
    idle(1, 1);
    commit(4'd1, 0, 1);
    idle(4, 1);

    // Same-cycle issue+commit, then a repeated commit
    cycle(1, mk(3'd0, 5'd7), 4'd7, 32'd40, 32'd2, 2'b11, 1, 4'd7, 0, 1);
    commit(4'd7, 0, 1);
    idle(2, 1);

    // Reset with entries queued
    issue(3'd0, 5'd1, 4'd1, 1, 1, 0);
    issue(3'd0, 5'd2, 4'd2, 2, 2, 0);
    cycle(1, mk(3'd0, 5'd3), 4'd3, 3, 3, 2'b11, 1, 4'd1, 0, 0);
    do_reset();
    commit(4'd2, 0, 1);
    commit(4'd3, 0, 1);
    idle(3, 1);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      bit          iv, cv, ck, rr;
      logic [31:0] instr;
      logic [3:0]  cid;
      logic [1:0]  rsv;
      iv    = ($urandom_range(0, 99) < 60);
      instr = ($urandom_range(0, 99) < 85) ? mk(3'($urandom_range(0, 7)), 5'($urandom))
                                           : $urandom;
      rsv   = ($urandom_range(0, 99) < 85) ? 2'b11 : 2'($urandom);
      cv    = ($urandom_range(0, 99) < 50);
      ck    = ($urandom_range(0, 99) < 25);
      rr    = ($urandom_range(0, 99) < 70);
      cid   = (mq.size() > 0 && $urandom_range(0, 99) < 75)
              ? mq[$urandom_range(0, mq.size() - 1)].id : 4'($urandom);
      cycle(iv, instr, 4'($urandom), $urandom, $urandom, rsv, cv, cid, ck, rr);
    end

    // Resolve whatever is left and drain
    for (int k = 0; k < 8; k++) begin
      if (mq.size() > 0) begin
        logic [3:0] cid;
        cid = mq[mq.size() - 1].id;
        foreach (mq[i]) if (!mq[i].cmt && !mq[i].kil) begin cid = mq[i].id; break; end
        commit(cid, 0, 1);
      end else begin
        idle(1, 1);
      end
    end
    idle(8, 1);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/xif_coproc_alu_frontend.md
# xif_coproc_alu_frontend

Coprocessor-side endpoint of the CV-X-IF issue, commit and result channels, attached to the `coproc_issue`, `coproc_commit` and `coproc_result` ends of the eXtension interface. It decodes offered instructions and accepts a small custom-0 ALU set. Accepted instructions are held in an in-order queue until the CPU commits or kills them. Committed instructions are executed and their results returned in issue order over the valid/ready result channel.

## Interface
- X_ID_WIDTH, 4: width of instruction ID fields.
- DEPTH, 4: queue entries; power of two, ≥2.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  CPU offers an instruction.
- issue_ready  out  1  handshake completes when issue_valid && issue_ready.
- issue_instr  in  32  offered instruction word.
- issue_id  in  X_ID_WIDTH  ID of offered instruction.
- issue_rs0, issue_rs1  in  32 each  source operands.
- issue_rs_valid  in  2  per-operand valid.
- issue_accept  out  1  instruction taken (valid only during handshake).
- issue_writeback  out  1  equals issue_accept.
- issue_dualwrite, issue_dualread, issue_loadstore, issue_exc  out  1 each  tied 0.
- commit_valid  in  1  commit event.
- commit_id  in  X_ID_WIDTH  committed/killed ID.
- commit_kill  in  1  1 = kill, 0 = commit.
- result_valid  out  1  result offered.
- result_ready  in  1  CPU takes result.
- result_id  out  X_ID_WIDTH  ID of result.
- result_data  out  32  result value.
- result_rd  out  5  destination register.
- result_we  out  1  (rd != 0).
- result_exc  out  1  tied 0.
- count  out  $clog2(DEPTH+1)  current queue occupancy.

## Operation
- Decode: accept iff instr[6:0]=7'b0001011, instr[31:25]=0, funct3 (instr[14:12]) ∈ {0..5}. Otherwise reject: issue_ready=1, accept=0, no state change.
- Ops on a=rs0, b=rs1: 000 ADD a+b mod 2^32; 001 SUB a−b mod 2^32; 010 XOR; 011 MINU; 100 MAXU; 101 ROTL a by b[4:0].
- Accept-class issue_ready = (count < DEPTH) && (issue_rs_valid == 2'b11). issue_ready is combinational from decode, rs_valid and registered count. It does not use same-cycle pop, so a full queue never pushes even while popping.
- Push on accept handshake. The entry stores id, rd=instr[11:7], funct3, a, b, committed=0, killed=0.
- Commit: on commit_valid, the first valid entry (from head) whose id = commit_id and whose committed=killed=0 is updated. Kill sets killed=1; commit sets committed=1. A commit matching no entry is ignored, as is a repeated commit for an already-resolved entry.
- If commit_valid targets the ID being pushed in the same cycle, the new entry is written with the commit/kill status already applied.
- Head processing:
  - Head killed: pop silently in one cycle, no result.
  - Head committed: drive result_valid=1, with result fields computed combinationally from the head entry. Pop on result_ready.
  - Head unresolved: result_valid=0 and wait.
- Results are strictly in issue order. A younger committed entry waits behind an unresolved head.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo DEPTH.

## Timing
- Reset: queue empty, count=0, result_valid=0. All result fields=0 and all issue_resp outputs=0. issue_ready is 1 after reset for any offered instruction with rs_valid=11 (queue empty).
- Reset mid-operation discards all entries immediately. No result is emitted for them.
- Issue response is same-cycle combinational with the handshake.
- Minimum latency: issue+commit in cycle N → result_valid in cycle N+1.
- Commit after issue in cycle M → result_valid in cycle M+1 if the entry is head.
- While result_valid && !result_ready, all result_* outputs are held stable.
- Throughput: one result per cycle with result_ready held high. A killed head costs one bubble cycle.

## Test plan
- Reset: assert rst mid-stream with 3 entries queued → count=0 and result_valid=0 next cycle. No stale result appears after release.
- Basic op, all six funct3 values:
  - ADD 0xFFFFFFFF+2 → 0x00000001.
  - ROTL 0x80000001 by 0x21 → 0x00000003.
  - MINU 5,0xFFFFFFFF → 5.
  - Check result_id, rd, and we=0 when rd=0.
- Reject: opcode 0x33 and funct3=6 → issue_ready=1, accept=0, count unchanged. A later commit for that ID produces no result.
- Backpressure/full: issue 4 with no commits → 5th issue_ready=0. Commit all with result_ready=0 → result_valid held with stable data. Release → 4 results in issue order on consecutive cycles.
- Kill and out-of-order commit: issue IDs 1,2,3; commit 3, kill 2, then commit 1 → results for ID 1, then ID 3 only; no result for ID 2.
- Same-cycle: issue ID 7 with commit_valid/commit_id=7/kill=0 in that same cycle → result in next cycle. Repeat the commit for ID 7 → ignored.
